// File: rtl/spi_packet_tx.sv
// spi_packet_tx: SPI mode-0 slave that snapshots a packer payload and shifts it out MSB-first on miso; define SPI_PKT_CRC8_EN to append a CRC-8 byte
module spi_packet_tx #(
  parameter int N_BYTES = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_BYTES-1:0][7:0] data_bytes,
  input  logic                    data_ready,
  output logic                    data_ack,
  input  logic                    sclk,
  input  logic                    cs_n,
  output logic                    miso,
  output logic                    pkt_irq,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    frame_abort,
  output logic [15:0]             frame_count
);
`ifdef SPI_PKT_CRC8_EN
  localparam int FRAME_LEN = N_BYTES + 1;
`else
  localparam int FRAME_LEN = N_BYTES;
`endif
  localparam int IW = $clog2(FRAME_LEN + 1);
  localparam int SW = $clog2(N_BYTES);
  localparam logic [IW-1:0] LEN_I = IW'(FRAME_LEN);
  localparam logic [IW-1:0] NB_I = IW'(N_BYTES);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nxt;
  logic [SYNC_STAGES-1:0] sclk_sync, cs_sync;
  logic sclk_prev, cs_prev, sclk_fall, cs_fall, cs_rise, capture, fresh;
  logic [N_BYTES-1:0][7:0] shadow;
  logic [IW-1:0] byte_idx;
  logic [2:0] bit_idx;
  logic [7:0] cur_byte, tail_byte;
  // SPI pins are asynchronous; cs_n syncs reset high so no false fall appears after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      cs_sync   <= '1;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], cs_n};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end
  assign sclk_fall = sclk_prev & ~sclk_sync[SYNC_STAGES-1];
  assign cs_fall   = cs_prev & ~cs_sync[SYNC_STAGES-1];
  assign cs_rise   = ~cs_prev & cs_sync[SYNC_STAGES-1];
  assign capture   = (state == IDLE) & data_ready;
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end
  // frame boundaries are set purely by chip select
  always_comb begin
    state_nxt = (state == IDLE && cs_fall) ? SHIFT : (state == SHIFT && cs_rise) ? IDLE : state;
  end
  // capture, bit/byte counters and frame status pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow      <= '0;
      fresh       <= 1'b0;
      data_ack    <= 1'b0;
      byte_idx    <= '0;
      bit_idx     <= 3'd0;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      frame_count <= 16'h0000;
    end else begin
      data_ack    <= capture;
      frame_done  <= 1'b0;
      frame_abort <= 1'b0;
      if (capture) shadow <= data_bytes;
      if (state == IDLE) begin
        if (cs_fall) begin
          fresh    <= 1'b0;
          byte_idx <= '0;
          bit_idx  <= 3'd7;
        end else if (capture) fresh <= 1'b1;
      end else if (cs_rise) begin
        frame_done  <= (byte_idx == LEN_I);
        frame_abort <= (byte_idx != LEN_I);
        if (byte_idx == LEN_I) frame_count <= frame_count + 16'd1;
      end else if (sclk_fall && byte_idx != LEN_I) begin
        bit_idx <= bit_idx - 3'd1;
        if (bit_idx == 3'd0) byte_idx <= byte_idx + 1'b1;
      end
    end
  end
`ifdef SPI_PKT_CRC8_EN
  logic [7:0] crc;
  function automatic logic [7:0] crc8(input logic [N_BYTES-1:0][7:0] d);
    logic [7:0] c;
    c = 8'h00;
    for (int i = 0; i < N_BYTES; i++) begin
      c = c ^ d[i];
      for (int j = 0; j < 8; j++) c = {c[6:0], 1'b0} ^ (c[7] ? 8'h07 : 8'h00);
    end
    return c;
  endfunction
  // CRC is registered alongside the shadow so it always describes the snapshot being sent
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          crc <= 8'h00;
    else if (capture) crc <= crc8(data_bytes);
  end
  assign tail_byte = (byte_idx == NB_I) ? crc : 8'h00;
`else
  assign tail_byte = 8'h00;
`endif
  assign cur_byte = (byte_idx < NB_I) ? shadow[byte_idx[SW-1:0]] : tail_byte;
  assign miso     = busy & cur_byte[bit_idx];
  assign busy     = (state == SHIFT);
  assign pkt_irq  = fresh;
endmodule

// File: tb/tb_spi_packet_tx.sv
// tb_spi_packet_tx: randomized scoreboard bench for spi_packet_tx
module tb_spi_packet_tx;
  localparam int N = 32;
`ifdef SPI_PKT_CRC8_EN
  localparam int LEN = N + 1;
  localparam bit CRC_EN = 1'b1;
`else
  localparam int LEN = N;
  localparam bit CRC_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0][7:0] data_bytes = '0;
  logic data_ready = 1'b0, sclk = 1'b0, cs_n = 1'b1;
  logic data_ack, miso, pkt_irq, busy, frame_done, frame_abort;
  logic [15:0] frame_count;
  spi_packet_tx #(.N_BYTES(N), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .data_bytes(data_bytes), .data_ready(data_ready),
    .data_ack(data_ack), .sclk(sclk), .cs_n(cs_n), .miso(miso), .pkt_irq(pkt_irq),
    .busy(busy), .frame_done(frame_done), .frame_abort(frame_abort), .frame_count(frame_count)
  );
  always #5 clk = ~clk;
  int n_checks = 0, n_fail = 0;
  int done_cnt = 0, abort_cnt = 0, ack_cnt = 0, ack_busy_cnt = 0;
  logic [7:0] model_shadow [N];
  logic model_fresh = 1'b0;
  logic [15:0] model_count = 16'h0000;
  logic [7:0] exp_q[$], rx_q[$];
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  function automatic logic [7:0] model_crc();
    logic [7:0] c = 8'h00;
    for (int i = 0; i < N; i++)
      for (int b = 7; b >= 0; b--) begin
        logic fb = c[7] ^ model_shadow[i][b];
        c = c << 1;
        if (fb) c = c ^ 8'h07;
      end
    return c;
  endfunction
  function automatic logic [7:0] model_byte(input int k);
    if (k < N) return model_shadow[k];
    if (CRC_EN && k == N) return model_crc();
    return 8'h00;
  endfunction
  // monitor: pulse bookkeeping and scoreboard comparison of bytes seen by the SPI master
  always @(negedge clk) begin
    if (data_ack) ack_cnt++;
    if (data_ack && busy) ack_busy_cnt++;
    if (frame_done) done_cnt++;
    if (frame_abort) abort_cnt++;
    if (rx_q.size() > 0) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL miso byte: got 0x%0h with no expected byte queued", rx_q.pop_front());
      end else chk("miso byte", rx_q.pop_front(), exp_q.pop_front());
    end
  end
  task automatic capture(input int mode);
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      data_bytes[i] = (mode == 0) ? 8'(i) : (mode == 1) ? 8'($urandom) : ((i == 0) ? 8'h01 : 8'h00);
      model_shadow[i] = data_bytes[i];
    end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    model_fresh = 1'b1;
    chk("data_ack pulse", data_ack, 1);
    @(negedge clk);
    chk("data_ack single", data_ack, 0);
    chk("pkt_irq after capture", pkt_irq, 1);
  endtask
  task automatic run_frame(input int pulses, input int ready_at, input int rst_at);
    logic [7:0] sh = 8'h00;
    logic [7:0] pend [N];
    int d0 = done_cnt, a0 = abort_cnt, nb, t = 0, w = 0;
    logic full = (pulses >= LEN * 8);
    nb = ((rst_at >= 0) ? rst_at : pulses) / 8;
    for (int k = 0; k < nb; k++) exp_q.push_back(model_byte(k));
    @(negedge clk);
    cs_n = 1'b0;
    #200;
    model_fresh = 1'b0;
    chk("busy in frame", busy, 1);
    chk("pkt_irq cleared", pkt_irq, 0);
    for (int k = 0; k < pulses; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        #30;
        chk("reset miso", miso, 0);
        chk("reset busy", busy, 0);
        chk("reset frame_count", frame_count, 0);
        chk("reset pkt_irq", pkt_irq, 0);
        cs_n = 1'b1;
        #30;
        rst = 1'b0;
        for (int i = 0; i < N; i++) model_shadow[i] = 8'h00;
        model_count = 16'h0000;
        model_fresh = 1'b0;
        return;
      end
      if (k == ready_at) begin
        for (int i = 0; i < N; i++) begin
          pend[i] = 8'($urandom);
          data_bytes[i] = pend[i];
        end
        data_ready = 1'b1;
      end
      sh = {sh[6:0], miso};
      sclk = 1'b1;
      #40;
      sclk = 1'b0;
      #40;
      if (k % 8 == 7) rx_q.push_back(sh);
    end
    #80;
    cs_n = 1'b1;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("busy released", busy, 0);
    if (ready_at >= 0 && ready_at < pulses) begin
      while (!data_ack && w < 5) begin
        @(negedge clk);
        w++;
      end
      chk("ack within 2 cycles of idle", (data_ack && w <= 2), 1);
      data_ready = 1'b0;
      for (int i = 0; i < N; i++) model_shadow[i] = pend[i];
      model_fresh = 1'b1;
    end
    repeat (3) @(negedge clk);
    if (full) model_count = model_count + 16'd1;
    chk("frame_done pulses", done_cnt - d0, full ? 1 : 0);
    chk("frame_abort pulses", abort_cnt - a0, full ? 0 : 1);
    chk("frame_count", frame_count, model_count);
    chk("pkt_irq after frame", pkt_irq, model_fresh);
  endtask
  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
  initial begin
    for (int i = 0; i < N; i++) model_shadow[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset miso", miso, 0);
    chk("reset busy", busy, 0);
    chk("reset pkt_irq", pkt_irq, 0);
    chk("reset data_ack", data_ack, 0);
    chk("reset frame_count", frame_count, 0);
    chk("reset done/abort", {frame_done, frame_abort}, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    capture(0);
    repeat (5) @(negedge clk);
    chk("single ack total", ack_cnt, 1);
    run_frame(LEN * 8, -1, -1);
    run_frame(100, 40, -1);
    run_frame(LEN * 8 + 8, -1, -1);
    run_frame(LEN * 8, -1, -1);
    if (CRC_EN) begin
      capture(2);
      run_frame(LEN * 8, -1, -1);
      run_frame(N * 8, -1, -1);
    end
    for (int r = 0; r < 6; r++) begin
      int sel = $urandom_range(0, 2);
      if ($urandom_range(0, 1) == 1) capture(1);
      run_frame(sel == 0 ? LEN * 8 : sel == 1 ? LEN * 8 + $urandom_range(1, 16) : $urandom_range(1, LEN * 8 - 1), -1, -1);
    end
    capture(1);
    run_frame(LEN * 8, -1, 50);
    repeat (5) @(negedge clk);
    run_frame(LEN * 8, -1, -1);
    repeat (5) @(negedge clk);
    chk("no ack during shift", ack_busy_cnt, 0);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
